ifetch_unit: RTL

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit: credit-based instruction fetch front end.
// Issues word-aligned fetch requests and tracks the in-flight ones. Returned
// words are buffered, together with their PC, in a DEPTH-entry FIFO that
// feeds the decoder. A redirect flushes the FIFO and drops every stale
// response still in flight.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   imem_req_valid/ready/addr         fetch request channel
//   imem_rsp_valid/data               in-order response channel (no back-pressure)
//   redirect_valid/redirect_pc        control-flow change
//   dec_valid/ready/instruction/pc    decoder channel (head of the FIFO)
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instruction,
  output logic [31:0] dec_pc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [31:0] RESET_ALIGNED = {RESET_PC[31:2], 2'b00};

  typedef enum logic {RUN, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        rsp_pc_q, rsp_pc_d;     // PC of the next response that will be kept
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

  logic [31:0]        mem_instr [DEPTH];
  logic [31:0]        mem_pc    [DEPTH];

  logic               req_fire;
  logic               wr_en;
  logic               rd_en;
  logic               dropping;
  logic [SUM_W-1:0]   credits_used;

  // Pointer increment with wrap at DEPTH-1 (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit gate: in-flight plus buffered words may never exceed the FIFO size.
  assign credits_used   = SUM_W'(outstanding_q) + SUM_W'(count_q);
  assign imem_req_valid = !rst && !redirect_valid && (credits_used < SUM_W'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign dropping = (state_q == DRAIN);
  assign wr_en    = imem_rsp_valid && !dropping && !redirect_valid;
  assign rd_en    = dec_valid && dec_ready && !redirect_valid;

  assign dec_valid       = (count_q != '0);
  assign dec_instruction = dec_valid ? mem_instr[rd_ptr_q] : 32'h0;
  assign dec_pc          = dec_valid ? mem_pc[rd_ptr_q] : 32'h0;

  // State register and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_ALIGNED;
      rsp_pc_q      <= RESET_ALIGNED;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // FIFO storage; contents only matter where count_q says they are valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_instr[wr_ptr_q] <= imem_rsp_data;
      mem_pc[wr_ptr_q]    <= rsp_pc_q;
    end
  end

  // Next-state logic; a redirect overrides FIFO writes/reads and drop updates.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    drop_d        = drop_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      rsp_pc_d   = {redirect_pc[31:2], 2'b00};
      // Everything still in flight after this edge is stale.
      drop_d     = outstanding_d;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (dropping && imem_rsp_valid) drop_d = drop_q - CNT_W'(1);
      if (wr_en) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end

    unique case (state_q)
      RUN: begin
        if (redirect_valid && (outstanding_d != '0)) state_d = DRAIN;
      end
      DRAIN: begin
        if (redirect_valid) state_d = (outstanding_d != '0) ? DRAIN : RUN;
        else if (drop_d == '0) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

endmodule
